// File: rtl/load_scoreboard_pkg.sv
// Shared types and constants for the load scoreboard: FSM states, default
// in-flight depth and register index width.
package scoreboard_pkg;
   localparam int DefaultMaxOutstanding = 4;
   localparam int RegIdxWidth           = 5;

   typedef enum logic [1:0] {RUN, DRAIN, DRAINED} sbState_t;
endpackage

// File: rtl/load_scoreboard_if.sv
// Decode-stage issue, load-return and drain signals plus scoreboard status.
interface load_scoreboard_if;
   import scoreboard_pkg::*;

   logic [RegIdxWidth-1:0] inRegisterRs;
   logic [RegIdxWidth-1:0] inRegisterRt;
   logic [RegIdxWidth-1:0] inDestRegister;
   logic                   inIssueValid;
   logic                   inIssueRegWrite;
   logic                   inIssueIsLoad;
   logic                   inLoadDone;
   logic [RegIdxWidth-1:0] inLoadDoneRegister;
   logic                   inFlush;
   logic                   inDrainReq;
   logic                   outStall;
   logic                   outDrained;
   logic [31:0]            outPendingMask;
   logic [3:0]             outOutstanding;
   logic                   outProtocolError;

   modport master (
      output inRegisterRs, inRegisterRt, inDestRegister, inIssueValid,
             inIssueRegWrite, inIssueIsLoad, inLoadDone, inLoadDoneRegister,
             inFlush, inDrainReq,
      input  outStall, outDrained, outPendingMask, outOutstanding,
             outProtocolError
   );

   modport slave (
      input  inRegisterRs, inRegisterRt, inDestRegister, inIssueValid,
             inIssueRegWrite, inIssueIsLoad, inLoadDone, inLoadDoneRegister,
             inFlush, inDrainReq,
      output outStall, outDrained, outPendingMask, outOutstanding,
             outProtocolError
   );
endinterface

// File: rtl/load_scoreboard.sv
// Tracks in-flight load destinations, stalls dependent issue (RAW/WAW/full),
// and supports a drain handshake that blocks issue until all loads return.
module load_scoreboard
   import scoreboard_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DefaultMaxOutstanding
) (
   input logic              clk,
   input logic              reset,
   load_scoreboard_if.slave sb
);

   logic [31:0] pending;
   logic [3:0]  count;
   sbState_t    state;
   logic        protoErr;

   logic [31:0] doneMask;
   logic [31:0] effPending;
   logic [31:0] setMask;
   logic [31:0] pendingNext;
   logic [3:0]  countNext;
   logic        doneOk;
   logic        raw;
   logic        waw;
   logic        full;
   logic        stall;
   logic        setLoad;

   always_comb begin
      doneMask = '0;
      if (sb.inLoadDone) doneMask[sb.inLoadDoneRegister] = 1'b1;
      // Returning data is forwarded, so its register no longer blocks issue.
      effPending = pending & ~doneMask;
      doneOk = sb.inLoadDone && pending[sb.inLoadDoneRegister] && (count != 4'd0);

      raw  = ((sb.inRegisterRs != '0) && effPending[sb.inRegisterRs]) ||
             ((sb.inRegisterRt != '0) && effPending[sb.inRegisterRt]);
      waw  = sb.inIssueRegWrite && (sb.inDestRegister != '0) &&
             effPending[sb.inDestRegister];
      // Only a genuine completion frees a slot; a bogus one must not let the count overflow.
      full = sb.inIssueIsLoad && (count == 4'(MAX_OUTSTANDING)) && !doneOk;
      stall = sb.inIssueValid && (raw || waw || full || (state != RUN));

      setLoad = sb.inIssueValid && !stall && !sb.inFlush && sb.inIssueIsLoad &&
                sb.inIssueRegWrite && (sb.inDestRegister != '0);
      setMask = '0;
      if (setLoad) setMask[sb.inDestRegister] = 1'b1;

      // Set wins over clear when the same register returns and reissues.
      pendingNext = (pending & ~(doneOk ? doneMask : 32'd0)) | setMask;
      countNext   = count + 4'(setLoad) - 4'(doneOk);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending  <= '0;
         count    <= '0;
         state    <= RUN;
         protoErr <= 1'b0;
      end else begin
         pending <= pendingNext;
         count   <= countNext;
         if (sb.inLoadDone && !doneOk) protoErr <= 1'b1;
         case (state)
            RUN:     if (sb.inDrainReq) state <= DRAIN;
            DRAIN:   if (!sb.inDrainReq) state <= RUN;
                     else if (countNext == 4'd0) state <= DRAINED;
            DRAINED: if (!sb.inDrainReq) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   assign sb.outStall         = stall;
   assign sb.outDrained       = (state == DRAINED);
   assign sb.outPendingMask   = pending;
   assign sb.outOutstanding   = count;
   assign sb.outProtocolError = protoErr;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed vector table, hand-written corner sequences and randomized run
// against a set-based reference model of the load scoreboard.
module tb_load_scoreboard;
   localparam int Max = 4;

   logic clk = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;

   load_scoreboard_if sbIf();

   load_scoreboard #(.MAX_OUTSTANDING(Max)) dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sbIf)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        rst;
      logic [4:0]  rs, rt, dest;
      logic        v, rw, ld, done;
      logic [4:0]  doneReg;
      logic        flush, drain;
      logic        expStall;
      logic [31:0] expMask;
      logic [3:0]  expCnt;
      logic        expDrained, expErr;
   } vec_t;

   function automatic vec_t mk(logic rst, logic [4:0] rs, logic [4:0] rt, logic [4:0] dest,
                               logic v, logic rw, logic ld, logic done, logic [4:0] doneReg,
                               logic flush, logic drain, logic expStall, logic [31:0] expMask,
                               logic [3:0] expCnt, logic expDrained, logic expErr);
      vec_t r;
      r.rst = rst; r.rs = rs; r.rt = rt; r.dest = dest; r.v = v; r.rw = rw; r.ld = ld;
      r.done = done; r.doneReg = doneReg; r.flush = flush; r.drain = drain;
      r.expStall = expStall; r.expMask = expMask; r.expCnt = expCnt;
      r.expDrained = expDrained; r.expErr = expErr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t t);
      reset                   = t.rst;
      sbIf.inRegisterRs       = t.rs;
      sbIf.inRegisterRt       = t.rt;
      sbIf.inDestRegister     = t.dest;
      sbIf.inIssueValid       = t.v;
      sbIf.inIssueRegWrite    = t.rw;
      sbIf.inIssueIsLoad      = t.ld;
      sbIf.inLoadDone         = t.done;
      sbIf.inLoadDoneRegister = t.doneReg;
      sbIf.inFlush            = t.flush;
      sbIf.inDrainReq         = t.drain;
   endtask

   // Called at posedge+1: combinational stall before the edge, registers after.
   task automatic applyVec(input string tag, input vec_t t);
      drive(t);
      #3;
      chk({tag, " stall"}, 32'(sbIf.outStall), 32'(t.expStall));
      @(posedge clk); #1;
      chk({tag, " mask"}, sbIf.outPendingMask, t.expMask);
      chk({tag, " count"}, 32'(sbIf.outOutstanding), 32'(t.expCnt));
      chk({tag, " drained"}, 32'(sbIf.outDrained), 32'(t.expDrained));
      chk({tag, " perr"}, 32'(sbIf.outProtocolError), 32'(t.expErr));
   endtask

   // Reference model: set of pending registers, drain mode, sticky error.
   bit mPend[32];
   int mMode;   // 0 run, 1 draining, 2 drained
   bit mErr;

   function automatic int mCount();
      int n = 0;
      for (int i = 0; i < 32; i++) n += int'(mPend[i]);
      return n;
   endfunction

   function automatic bit mStall(vec_t t);
      bit eff[32];
      for (int i = 0; i < 32; i++) eff[i] = mPend[i] && !(t.done && t.doneReg == 5'(i));
      if (!t.v) return 1'b0;
      return (t.rs != 0 && eff[t.rs]) || (t.rt != 0 && eff[t.rt]) ||
             (t.rw && t.dest != 0 && eff[t.dest]) ||
             (t.ld && mCount() == Max && !t.done) || (mMode != 0);
   endfunction

   function automatic void mStep(vec_t t, bit st);
      if (t.rst) begin
         foreach (mPend[i]) mPend[i] = 1'b0;
         mMode = 0;
         mErr  = 1'b0;
         return;
      end
      if (t.done) begin
         if (mPend[t.doneReg] && mCount() > 0) mPend[t.doneReg] = 1'b0;
         else mErr = 1'b1;
      end
      if (t.v && !st && !t.flush && t.ld && t.rw && t.dest != 0) mPend[t.dest] = 1'b1;
      case (mMode)
         0: if (t.drain) mMode = 1;
         1: if (!t.drain) mMode = 0; else if (mCount() == 0) mMode = 2;
         default: if (!t.drain) mMode = 0;
      endcase
   endfunction

   vec_t tbl[$];
   vec_t rv;
   logic drainLvl;
   bit   expStall;
   logic [31:0] expMask;

   initial begin
      drive(mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 0, 0,0,0,0));
      repeat (2) @(posedge clk);
      #1;
      chk("reset mask", sbIf.outPendingMask, 32'h0);
      chk("reset count", 32'(sbIf.outOutstanding), 32'h0);
      chk("reset drained", 32'(sbIf.outDrained), 32'h0);
      chk("reset perr", 32'(sbIf.outProtocolError), 32'h0);

      // RAW on r5 until its data returns, with bypass on the return cycle
      tbl.push_back(mk(0, 0,0,5,  1,1,1, 0,0, 0,0, 0, 32'h20,1,0,0));
      tbl.push_back(mk(0, 5,0,10, 1,1,0, 0,0, 0,0, 1, 32'h20,1,0,0));
      tbl.push_back(mk(0, 5,0,10, 1,1,0, 0,0, 0,0, 1, 32'h20,1,0,0));
      tbl.push_back(mk(0, 5,0,10, 1,1,0, 1,5, 0,0, 0, 32'h0,0,0,0));
      // r0 is never tracked
      tbl.push_back(mk(0, 0,0,0,  1,1,1, 0,0, 0,0, 0, 32'h0,0,0,0));
      tbl.push_back(mk(0, 0,0,3,  1,1,0, 0,0, 0,0, 0, 32'h0,0,0,0));
      // fill to capacity, then fifth load blocked until a same-cycle return
      tbl.push_back(mk(0, 0,0,1,  1,1,1, 0,0, 0,0, 0, 32'h2,1,0,0));
      tbl.push_back(mk(0, 0,0,2,  1,1,1, 0,0, 0,0, 0, 32'h6,2,0,0));
      tbl.push_back(mk(0, 0,0,3,  1,1,1, 0,0, 0,0, 0, 32'hE,3,0,0));
      tbl.push_back(mk(0, 0,0,4,  1,1,1, 0,0, 0,0, 0, 32'h1E,4,0,0));
      tbl.push_back(mk(0, 0,0,6,  1,1,1, 0,0, 0,0, 1, 32'h1E,4,0,0));
      tbl.push_back(mk(0, 0,0,6,  1,1,1, 1,2, 0,0, 0, 32'h5A,4,0,0));
      tbl.push_back(mk(0, 0,0,0,  0,0,0, 1,1, 0,0, 0, 32'h58,3,0,0));
      tbl.push_back(mk(0, 0,0,0,  0,0,0, 1,3, 0,0, 0, 32'h50,2,0,0));
      tbl.push_back(mk(0, 0,0,0,  0,0,0, 1,4, 0,0, 0, 32'h40,1,0,0));
      tbl.push_back(mk(0, 0,0,0,  0,0,0, 1,6, 0,0, 0, 32'h0,0,0,0));
      // drain with two loads in flight
      tbl.push_back(mk(0, 0,0,7,  1,1,1, 0,0, 0,0, 0, 32'h80,1,0,0));
      tbl.push_back(mk(0, 0,0,8,  1,1,1, 0,0, 0,0, 0, 32'h180,2,0,0));
      tbl.push_back(mk(0, 0,0,0,  0,0,0, 0,0, 0,1, 0, 32'h180,2,0,0));
      tbl.push_back(mk(0, 1,2,11, 1,1,0, 0,0, 0,1, 1, 32'h180,2,0,0));
      tbl.push_back(mk(0, 1,2,11, 1,1,0, 1,7, 0,1, 1, 32'h100,1,0,0));
      tbl.push_back(mk(0, 0,0,0,  0,0,0, 1,8, 0,1, 0, 32'h0,0,1,0));
      tbl.push_back(mk(0, 1,2,11, 1,1,0, 0,0, 0,1, 1, 32'h0,0,1,0));
      tbl.push_back(mk(0, 1,2,11, 1,1,0, 0,0, 0,0, 1, 32'h0,0,0,0));
      tbl.push_back(mk(0, 1,2,11, 1,1,0, 0,0, 0,0, 0, 32'h0,0,0,0));
      // bogus return for r9 while r7 is pending
      tbl.push_back(mk(0, 0,0,7,  1,1,1, 0,0, 0,0, 0, 32'h80,1,0,0));
      tbl.push_back(mk(0, 0,0,0,  0,0,0, 1,9, 0,0, 0, 32'h80,1,0,1));
      tbl.push_back(mk(0, 0,0,0,  0,0,0, 0,0, 0,0, 0, 32'h80,1,0,1));
      // reset mid-flight discards r7; a load issued under reset is ignored
      tbl.push_back(mk(1, 0,0,9,  1,1,1, 0,0, 0,0, 0, 32'h0,0,0,0));
      tbl.push_back(mk(0, 7,0,12, 1,1,0, 0,0, 0,0, 0, 32'h0,0,0,0));

      foreach (tbl[i]) applyVec($sformatf("vec%0d", i), tbl[i]);

      // same-register return and reissue, flush, aborted drain, bogus r0 return
      applyVec("hs load r12",   mk(0, 0,0,12, 1,1,1, 0,0,  0,0, 0, 32'h1000,1,0,0));
      applyVec("hs set+clr r12",mk(0, 0,0,12, 1,1,1, 1,12, 0,0, 0, 32'h1000,1,0,0));
      applyVec("hs flush r13",  mk(0, 0,0,13, 1,1,1, 0,0,  1,0, 0, 32'h1000,1,0,0));
      applyVec("hs drain on",   mk(0, 0,0,0,  0,0,0, 0,0,  1,1, 0, 32'h1000,1,0,0));
      applyVec("hs drain off",  mk(0, 1,2,11, 1,1,0, 0,0,  0,0, 1, 32'h1000,1,0,0));
      applyVec("hs run again",  mk(0, 1,2,11, 1,1,0, 0,0,  0,0, 0, 32'h1000,1,0,0));
      applyVec("hs done r12",   mk(0, 0,0,0,  0,0,0, 1,12, 0,0, 0, 32'h0,0,0,0));
      applyVec("hs done r0",    mk(0, 0,0,0,  0,0,0, 1,0,  0,0, 0, 32'h0,0,0,1));

      // randomized run against the model, starting from a reset
      drainLvl = 1'b0;
      rv = mk(1, 0,0,0, 0,0,0, 0,0, 0,0, 0, 0,0,0,0);
      mStep(rv, 1'b0);
      drive(rv);
      @(posedge clk); #1;
      for (int n = 0; n < 600; n++) begin
         int r;
         int q[$];
         rv.rst   = ($urandom_range(0, 99) < 2);
         rv.rs    = 5'($urandom_range(0, 7));
         rv.rt    = 5'($urandom_range(0, 7));
         rv.dest  = 5'($urandom_range(0, 7));
         rv.v     = ($urandom_range(0, 99) < 75);
         rv.ld    = ($urandom_range(0, 99) < 50);
         rv.rw    = ($urandom_range(0, 99) < 85);
         rv.flush = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 99) < 5) drainLvl = !drainLvl;
         rv.drain = drainLvl;
         rv.done  = 1'b0;
         rv.doneReg = 5'($urandom_range(0, 31));
         r = $urandom_range(0, 99);
         foreach (mPend[i]) if (mPend[i]) q.push_back(i);
         if (r < 40 && q.size() > 0) begin
            rv.done = 1'b1;
            rv.doneReg = 5'(q[$urandom_range(0, q.size() - 1)]);
         end else if (r < 43 && mCount() < Max) begin
            rv.done = 1'b1;
            do rv.doneReg = 5'($urandom_range(0, 31)); while (mPend[rv.doneReg]);
         end
         drive(rv);
         #3;
         expStall = mStall(rv);
         chk($sformatf("rnd%0d stall", n), 32'(sbIf.outStall), 32'(expStall));
         mStep(rv, expStall);
         @(posedge clk); #1;
         expMask = '0;
         foreach (mPend[i]) expMask[i] = mPend[i];
         chk($sformatf("rnd%0d mask", n), sbIf.outPendingMask, expMask);
         chk($sformatf("rnd%0d count", n), 32'(sbIf.outOutstanding), 32'(mCount()));
         chk($sformatf("rnd%0d drained", n), 32'(sbIf.outDrained), 32'(mMode == 2));
         chk($sformatf("rnd%0d perr", n), 32'(sbIf.outProtocolError), 32'(mErr));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
